// File: rtl/io_periph_pkg.sv
// Purpose: shared register map, select type and helpers for the I/O peripheral bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_periph_pkg;

  // Byte offsets inside the 4 KiB window. Decoding uses address bits [11:2].
  localparam logic [11:0] OFF_LEDR  = 12'h000;
  localparam logic [11:0] OFF_LEDG  = 12'h010;
  localparam logic [11:0] OFF_HEX   = 12'h020;
  localparam logic [11:0] OFF_LCD   = 12'h030;
  localparam logic [11:0] OFF_SW    = 12'h800;
  localparam logic [11:0] OFF_CYCLE = 12'h810;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LEDR,
    REG_LEDG,
    REG_HEX,
    REG_LCD,
    REG_SW,
    REG_CYCLE
  } io_reg_e;

  // Four seven-segment digits are packed per 32-bit word.
  function automatic int hex_words(input int num_hex);
    return (num_hex + 3) / 4;
  endfunction

  // Replace the bytes of old_val selected by mask with the bytes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_periph_bank_sw_debounce.sv
// Purpose: two-flop synchroniser plus stable-count debouncer for the switch inputs.
// Latency: 2 + DEBOUNCE_CYC + 1 cycles from a clean raw step to sw_db (3 with bypass).
// Backpressure: none; free-running sampler.
// Ports: clk, reset (sync, active-high), sw_raw (asynchronous switches), sw_db (debounced value).
module sw_debounce
  import io_periph_pkg::*;
#(
  parameter int SW_W         = 32,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] sw_db
);

  logic [SW_W-1:0] sync1;
  logic [SW_W-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE_CYC == 0) begin : g_bypass
    always_ff @(posedge clk) begin
      if (reset) sw_db <= '0;
      else       sw_db <= sync2;
    end
  end else begin : g_filter
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic [SW_W-1:0]  cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        cand  <= '0;
        cnt   <= '0;
        sw_db <= '0;
      end else if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
        // Commit on the same edge the counter reaches its limit.
        if (cnt == CNT_MAX - CNT_W'(1)) sw_db <= cand;
      end
    end
  end

endmodule

// File: rtl/io_periph_bank.sv
// Purpose: memory-mapped LED/HEX/LCD output registers, debounced switches and cycle counter.
// Latency: stores visible next cycle; loads return data exactly 1 cycle after i_rden.
// Backpressure: none; accepts a load or store every cycle.
// Ports: i_clk, i_reset (sync, active-high); LSU side i_addr/i_wdata/i_bmask/i_wren/i_rden,
//        o_hit (combinational decode), o_rdata/o_rvalid; pins o_io_ledr/ledg/hex/lcd, i_io_sw.
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7000,
  parameter int          NUM_HEX      = 8,
  parameter int          LEDR_W       = 32,
  parameter int          LEDG_W       = 32,
  parameter int          SW_W         = 32,
  parameter int          DEBOUNCE_CYC = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_bmask,
  input  logic                 i_wren,
  input  logic                 i_rden,
  output logic                 o_hit,
  output logic [31:0]          o_rdata,
  output logic                 o_rvalid,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [NUM_HEX*7-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  input  logic [SW_W-1:0]      i_io_sw
);

  localparam int HEX_WORDS = hex_words(NUM_HEX);

  logic [11:0]       off;
  logic [1:0]        hex_idx;
  io_reg_e           sel;
  logic              wr;
  logic              unused_addr_bits;

  logic [6:0]        digit [NUM_HEX];
  logic [31:0]       cycle;
  logic [SW_W-1:0]   sw_db;

  logic [31:0]       ledr_x, ledg_x, sw_x, hex_x, rd_mux;
  logic [31:0]       ledr_w, ledg_w, lcd_w;

  // Byte lane within a word does not affect decode.
  assign off              = {i_addr[11:2], 2'b00};
  assign hex_idx          = i_addr[3:2];
  assign unused_addr_bits = ^i_addr[1:0];

  always_comb begin
    sel = REG_NONE;
    if (i_addr[31:12] == BASE_ADDR[31:12]) begin
      if (off == OFF_LEDR)                                         sel = REG_LEDR;
      else if (off == OFF_LEDG)                                    sel = REG_LEDG;
      else if (off[11:4] == OFF_HEX[11:4] && int'(hex_idx) < HEX_WORDS) sel = REG_HEX;
      else if (off == OFF_LCD)                                     sel = REG_LCD;
      else if (off == OFF_SW)                                      sel = REG_SW;
      else if (off == OFF_CYCLE)                                   sel = REG_CYCLE;
    end
  end

  assign o_hit = (sel != REG_NONE);
  assign wr    = i_wren & o_hit;

  // Zero-extended views of the narrow registers, used for both reads and byte merges.
  always_comb begin
    ledr_x = '0;
    ledr_x[LEDR_W-1:0] = o_io_ledr;
    ledg_x = '0;
    ledg_x[LEDG_W-1:0] = o_io_ledg;
    sw_x = '0;
    sw_x[SW_W-1:0] = sw_db;
    hex_x = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      if (int'(hex_idx) == k / 4) hex_x[8*(k%4) +: 7] = digit[k];
    end
    ledr_w = byte_merge(ledr_x, i_wdata, i_bmask);
    ledg_w = byte_merge(ledg_x, i_wdata, i_bmask);
    lcd_w  = byte_merge(o_io_lcd, i_wdata, i_bmask);
  end

  always_comb begin
    case (sel)
      REG_LEDR:  rd_mux = ledr_x;
      REG_LEDG:  rd_mux = ledg_x;
      REG_HEX:   rd_mux = hex_x;
      REG_LCD:   rd_mux = o_io_lcd;
      REG_SW:    rd_mux = sw_x;
      REG_CYCLE: rd_mux = cycle;
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) o_io_hex[7*k +: 7] = digit[k];
  end

  // Read samples pre-edge state, so a same-cycle store to the same register returns the old value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      cycle     <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
      for (int k = 0; k < NUM_HEX; k++) digit[k] <= '0;
    end else begin
      cycle    <= cycle + 32'd1;
      o_rvalid <= i_rden;
      if (i_rden) o_rdata <= rd_mux;
      if (wr && sel == REG_LEDR) o_io_ledr <= ledr_w[LEDR_W-1:0];
      if (wr && sel == REG_LEDG) o_io_ledg <= ledg_w[LEDG_W-1:0];
      if (wr && sel == REG_LCD)  o_io_lcd  <= lcd_w;
      for (int k = 0; k < NUM_HEX; k++) begin
        if (wr && sel == REG_HEX && int'(hex_idx) == k / 4 && i_bmask[k%4])
          digit[k] <= i_wdata[8*(k%4) +: 7];
      end
    end
  end

  sw_debounce #(
    .SW_W         (SW_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk    (i_clk),
    .reset  (i_reset),
    .sw_raw (i_io_sw),
    .sw_db  (sw_db)
  );

endmodule

// File: tb/tb_io_periph_bank.sv
// Purpose: directed scoreboard bench for io_periph_bank (wide instance A, narrow instance B).
// Latency: loads expected exactly one cycle after issue.
// Backpressure: none exercised; DUT accepts every cycle.
module tb_io_periph_bank;

  localparam logic [31:0] BASE = 32'h0000_7000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [3:0]  bmask;
  logic        wren, rden;
  logic [31:0] sw;

  logic        hit_a, rvalid_a;
  logic [31:0] rdata_a, ledr_a, ledg_a, lcd_a;
  logic [55:0] hex_a;

  logic        hit_b, rvalid_b;
  logic [31:0] rdata_b, lcd_b;
  logic [9:0]  ledr_b;
  logic [7:0]  ledg_b;
  logic [41:0] hex_b;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] last_a = '0, last_b = '0;
  logic        mon_ld, mon_rs;
  logic [31:0] ea, eb;

  always #5 clk = ~clk;

  io_periph_bank #(
    .BASE_ADDR(BASE), .NUM_HEX(8), .LEDR_W(32), .LEDG_W(32), .SW_W(32), .DEBOUNCE_CYC(4)
  ) dut_a (
    .i_clk(clk), .i_reset(reset), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_wren(wren), .i_rden(rden), .o_hit(hit_a), .o_rdata(rdata_a), .o_rvalid(rvalid_a),
    .o_io_ledr(ledr_a), .o_io_ledg(ledg_a), .o_io_hex(hex_a), .o_io_lcd(lcd_a),
    .i_io_sw(sw)
  );

  io_periph_bank #(
    .BASE_ADDR(BASE), .NUM_HEX(6), .LEDR_W(10), .LEDG_W(8), .SW_W(2), .DEBOUNCE_CYC(4)
  ) dut_b (
    .i_clk(clk), .i_reset(reset), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_wren(wren), .i_rden(rden), .o_hit(hit_b), .o_rdata(rdata_b), .o_rvalid(rvalid_b),
    .o_io_ledr(ledr_b), .o_io_ledg(ledg_b), .o_io_hex(hex_b), .o_io_lcd(lcd_b),
    .i_io_sw(sw[1:0])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every load issued on an edge must show up right after that edge.
  always @(posedge clk) begin
    mon_ld = rden;
    mon_rs = reset;
    #1;
    if (mon_rs) begin
      chk("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
      chk("rst_rdata_a", rdata_a, 32'd0);
      chk("rst_rdata_b", rdata_b, 32'd0);
      last_a = '0;
      last_b = '0;
    end else if (mon_ld) begin
      chk("rvalid_a", {31'd0, rvalid_a}, 32'd1);
      chk("rvalid_b", {31'd0, rvalid_b}, 32'd1);
      if (qa.size() == 0 || qb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("load_a", rdata_a, ea);
        chk("load_b", rdata_b, eb);
        last_a = ea;
        last_b = eb;
      end
    end else begin
      chk("idle_rvalid_a", {31'd0, rvalid_a}, 32'd0);
      chk("idle_rvalid_b", {31'd0, rvalid_b}, 32'd0);
      chk("hold_rdata_a", rdata_a, last_a);
      chk("hold_rdata_b", rdata_b, last_b);
    end
  end

  // Each task starts just after a falling edge and returns at the next one.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; bmask = m; wren = 1'b1; rden = 1'b0;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b);
    addr = a; rden = 1'b1; wren = 1'b0;
    qa.push_back(exp_a);
    qb.push_back(exp_b);
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic hit_chk(input string name, input logic [31:0] a, input logic exp_a, input logic exp_b);
    addr = a;
    #1;
    chk({name, "_a"}, {31'd0, hit_a}, {31'd0, exp_a});
    chk({name, "_b"}, {31'd0, hit_b}, {31'd0, exp_b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0; bmask = '0; sw = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_ledr_a", ledr_a, 32'd0);
    chk("rst_ledg_a", ledg_a, 32'd0);
    chk("rst_lcd_a",  lcd_a,  32'd0);
    chk("rst_hexlo_a", hex_a[31:0], 32'd0);
    chk("rst_hexhi_a", {8'd0, hex_a[55:32]}, 32'd0);

    // Full-word store and readback.
    store(BASE + 32'h000, 32'h0000_00A5, 4'b1111);
    chk("ledr_a5_a", ledr_a, 32'h0000_00A5);
    chk("ledr_a5_b", {22'd0, ledr_b}, 32'h0000_00A5);
    load(BASE + 32'h000, 32'h0000_00A5, 32'h0000_00A5);

    // Byte mask with narrow truncation: B keeps only 10 bits.
    store(BASE + 32'h000, 32'hFFFF_FFFF, 4'b0101);
    chk("ledr_mask_a", ledr_a, 32'h00FF_00FF);
    chk("ledr_mask_b", {22'd0, ledr_b}, 32'h0000_00FF);
    load(BASE + 32'h003, 32'h00FF_00FF, 32'h0000_00FF);

    store(BASE + 32'h010, 32'hABCD_1234, 4'b1111);
    load(BASE + 32'h010, 32'hABCD_1234, 32'h0000_0034);

    // HEX word 1, then patch digit 5 alone.
    store(BASE + 32'h024, 32'h7F06_5B4F, 4'b1111);
    store(BASE + 32'h024, 32'h0000_1200, 4'b0010);
    chk("hex4_a", {25'd0, hex_a[28 +: 7]}, 32'h4F);
    chk("hex5_a", {25'd0, hex_a[35 +: 7]}, 32'h12);
    chk("hex6_a", {25'd0, hex_a[42 +: 7]}, 32'h06);
    chk("hex7_a", {25'd0, hex_a[49 +: 7]}, 32'h7F);
    chk("hex5_b", {25'd0, hex_b[35 +: 7]}, 32'h12);
    load(BASE + 32'h024, 32'h7F06_124F, 32'h0000_124F);

    // Digits beyond NUM_HEX on B stay absent.
    store(BASE + 32'h024, 32'hFFFF_FFFF, 4'b1111);
    chk("hex4_b", {25'd0, hex_b[28 +: 7]}, 32'h7F);
    chk("hex5_b_ff", {25'd0, hex_b[35 +: 7]}, 32'h7F);
    load(BASE + 32'h024, 32'h7F7F_7F7F, 32'h0000_7F7F);
    hit_chk("hit_hex1", BASE + 32'h024, 1'b1, 1'b1);
    hit_chk("hit_hex2", BASE + 32'h028, 1'b0, 1'b0);
    store(BASE + 32'h028, 32'hFFFF_FFFF, 4'b1111);
    load(BASE + 32'h028, 32'h0, 32'h0);

    // Bit 7 of each HEX byte is discarded.
    store(BASE + 32'h020, 32'h80FF_0081, 4'b1111);
    load(BASE + 32'h020, 32'h007F_0001, 32'h007F_0001);

    // Same-cycle read/write on LCD returns the old value.
    store(BASE + 32'h030, 32'h0000_1234, 4'b1111);
    addr = BASE + 32'h030; wdata = 32'h0000_BEEF; bmask = 4'b1111; wren = 1'b1; rden = 1'b1;
    qa.push_back(32'h0000_1234);
    qb.push_back(32'h0000_1234);
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
    chk("lcd_new_a", lcd_a, 32'h0000_BEEF);
    chk("lcd_new_b", lcd_b, 32'h0000_BEEF);
    load(BASE + 32'h030, 32'h0000_BEEF, 32'h0000_BEEF);

    // Unmapped and out-of-window addresses.
    hit_chk("hit_gap", BASE + 32'h040, 1'b0, 1'b0);
    hit_chk("hit_outside", 32'h0000_8000, 1'b0, 1'b0);
    hit_chk("hit_sw", BASE + 32'h800, 1'b1, 1'b1);
    load(BASE + 32'h040, 32'h0, 32'h0);

    // Stores to SW are ignored.
    store(BASE + 32'h800, 32'hFFFF_FFFF, 4'b1111);
    load(BASE + 32'h800, 32'h0, 32'h0);

    // A 3-cycle glitch to 0x1, then a clean step to 0x3. The debounced register updates on
    // the 7th edge after the step, so the first load to see 0x3 is the one on the 8th edge.
    sw = 32'h1;
    repeat (3) load(BASE + 32'h800, 32'h0, 32'h0);
    sw = 32'h3;
    for (int k = 1; k <= 10; k++) begin
      load(BASE + 32'h800, (k >= 8) ? 32'h3 : 32'h0, (k >= 8) ? 32'h3 : 32'h0);
    end

    // Reset, then let CYCLE reach 100 with LEDG set.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    store(BASE + 32'h010, 32'h0000_00FF, 4'b1111);
    chk("ledg_ff_a", ledg_a, 32'h0000_00FF);
    chk("ledg_ff_b", {24'd0, ledg_b}, 32'h0000_00FF);
    repeat (98) @(negedge clk);
    load(BASE + 32'h810, 32'd99, 32'd99);

    // Reset dominates a same-cycle store and load.
    reset = 1'b1; addr = BASE + 32'h010; wdata = 32'h11; bmask = 4'b1111; wren = 1'b1; rden = 1'b1;
    @(negedge clk);
    reset = 1'b0; wren = 1'b0; rden = 1'b0;
    chk("rst_ledg_a", ledg_a, 32'd0);
    chk("rst_ledg_b", {24'd0, ledg_b}, 32'd0);
    load(BASE + 32'h810, 32'd0, 32'd0);
    load(BASE + 32'h810, 32'd1, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_drain_a", qa.size(), 32'd0);
    chk("sb_drain_b", qb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
